// File: rtl/calc_pkg.sv
// Shared calculator definitions: word widths, decimal range limit and the
// binary-to-BCD converter state encoding. Also used by the keypad/operand logic.
package calc_pkg;

    localparam int BIN_W_DEF  = 14;
    localparam int DIGITS_DEF = 4;
    localparam int DIGIT_W    = 4;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic int unsigned dec_max(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam int unsigned MAX_DEC = dec_max(DIGITS_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } b2b_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Per-digit add-3 correction.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result bit per cycle.
// Optional build macro: OVF_SATURATE_EN -- out-of-range inputs load all-nines
// into bcd_out instead of the truncated low digits.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; captures bin_in on an accepted start
// SHIFT  | BIN_W correct-and-shift steps, counter runs down to zero
// FINISH | publish scratch/overflow, pulse done, return to IDLE
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = dec_max(DIGITS);

    b2b_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [BIN_W-1:0]      binreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic                  ovf_pend;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[g*DIGIT_W +: DIGIT_W]),
            .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the counter reaching its last step ends SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, correct-and-shift, publish. Carry out of the top digit is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            binreg   <= '0;
            scratch  <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        binreg   <= bin_in;
                        scratch  <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        ovf_pend <= (32'(bin_in) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[4*DIGITS-2:0], binreg[BIN_W-1]};
                    binreg  <= {binreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                end
                FINISH: begin
`ifdef OVF_SATURATE_EN
                    bcd_out <= ovf_pend ? {DIGITS{4'h9}} : scratch;
`else
                    bcd_out <= scratch;
`endif
                    overflow <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (BIN_W=14, DIGITS=4).
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int lat;
    int bcnt;
    int dcnt;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

`ifdef OVF_SATURATE_EN
    localparam logic [15:0] EXP_10000 = 16'h9999;
    localparam logic [15:0] EXP_16383 = 16'h9999;
`else
    localparam logic [15:0] EXP_10000 = 16'h0000;
    localparam logic [15:0] EXP_16383 = 16'h6383;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a one-cycle start pulse; returns #1 after the sampling edge.
    task automatic kick(input logic [13:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Count cycles from the start edge to done, and cycles with busy high.
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = busy ? 1 : 0;
        while (!done && l < 40) begin
            @(posedge clk); #1;
            l++;
            if (busy) b++;
        end
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd",  32'(bcd_out), 32'h0);
        chk("reset_ovf",  32'(overflow), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // zero
        kick(14'd0);
        wait_done(lat, bcnt);
        chk("zero_latency", 32'(lat), 32'd15);
        chk("zero_bcd", 32'(bcd_out), 32'h0000);
        chk("zero_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;

        // 1234, busy width and done width
        kick(14'd1234);
        wait_done(lat, bcnt);
        chk("1234_latency", 32'(lat), 32'd15);
        chk("1234_busy_cycles", 32'(bcnt), 32'd15);
        chk("1234_bcd", 32'(bcd_out), 32'h1234);
        chk("1234_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        chk("1234_done_width", 32'(done), 32'd0);
        chk("1234_bcd_held", 32'(bcd_out), 32'h1234);

        // 9999 then 10000 started in the done cycle
        kick(14'd9999);
        wait_done(lat, bcnt);
        chk("9999_bcd", 32'(bcd_out), 32'h9999);
        chk("9999_ovf", 32'(overflow), 32'd0);
        kick(14'd10000);
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        chk("10000_latency", 32'(lat), 32'd15);
        chk("10000_bcd", 32'(bcd_out), 32'(EXP_10000));
        chk("10000_ovf", 32'(overflow), 32'd1);
        @(posedge clk); #1;

        // full scale
        kick(14'd16383);
        wait_done(lat, bcnt);
        chk("16383_bcd", 32'(bcd_out), 32'(EXP_16383));
        chk("16383_ovf", 32'(overflow), 32'd1);
        @(posedge clk); #1;

        // start while busy is ignored
        kick(14'd42);
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        bin_in = 14'd777;
        @(posedge clk); #1;
        start  = 1'b0;
        dcnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("busy_start_dones", 32'(dcnt), 32'd1);
        chk("busy_start_bcd", 32'(bcd_out), 32'h0042);
        chk("busy_start_ovf", 32'(overflow), 32'd0);

        // mid-conversion reset aborts
        kick(14'd5678);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'h0000);
        chk("abort_ovf", 32'(overflow), 32'd0);
        dcnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        kick(14'd5678);
        wait_done(lat, bcnt);
        chk("after_abort_latency", 32'(lat), 32'd15);
        chk("after_abort_bcd", 32'(bcd_out), 32'h5678);

        // reset wins over start
        @(posedge clk); #1;
        rst    = 1'b0;
        start  = 1'b1;
        bin_in = 14'd321;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        chk("rst_vs_start_busy", 32'(busy), 32'd0);
        chk("rst_vs_start_bcd", 32'(bcd_out), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
